// File: rtl/weight_loader.sv
// Streams KERNEL_SIZE*KERNEL_SIZE signed 2-bit taps per feature into a kernel
// register and issues one active-low write per completed kernel to the feature memory.
module weight_loader #(
   parameter int KERNEL_SIZE  = 3,
   parameter int NUM_FEATURES = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_loader,
   input  logic                                     start_n,
   input  logic                                     w_valid,
   input  logic signed [1:0]                        w_data,
   output logic                                     w_ready,
   output logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0]     weights_output,
   output logic [$clog2(NUM_FEATURES):0]            feature_writeAddr,
   output logic                                     feature_WrEn,
   output logic                                     busy,
   output logic                                     load_done
);

   localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int TAP_W  = $clog2(TAPS + 1);
   localparam int FEAT_W = $clog2(NUM_FEATURES) + 1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [TAP_W-1:0]    r_tapCnt;
   logic [FEAT_W-1:0]   r_featCnt;
   logic signed [1:0]   r_kernel [TAPS];
   logic                w_transfer;
   logic                w_lastTap;
   logic                w_lastFeature;

   assign w_transfer    = w_valid && (r_state == COLLECT);
   assign w_lastTap     = (r_tapCnt == TAP_W'(TAPS - 1));
   assign w_lastFeature = (r_featCnt == FEAT_W'(NUM_FEATURES - 1));

   always_ff @(posedge clk or negedge rst_loader) begin
      if (!rst_loader) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (!start_n) w_nextState = COLLECT;
         COLLECT: if (w_transfer && w_lastTap) w_nextState = WRITE;
         WRITE:   w_nextState = w_lastFeature ? DONE : COLLECT;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Feature counter is left at its final value after DONE; it only matters during WRITE.
   always_ff @(posedge clk or negedge rst_loader) begin
      if (!rst_loader) begin
         r_tapCnt  <= '0;
         r_featCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!start_n) begin
                  r_tapCnt  <= '0;
                  r_featCnt <= '0;
               end
            end
            COLLECT: begin
               if (w_transfer) r_tapCnt <= r_tapCnt + TAP_W'(1);
            end
            WRITE: begin
               if (!w_lastFeature) begin
                  r_featCnt <= r_featCnt + FEAT_W'(1);
                  r_tapCnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_loader) begin
      if (!rst_loader) begin
         for (int i = 0; i < TAPS; i++) r_kernel[i] <= '0;
      end else if (w_transfer) begin
         for (int i = 0; i < TAPS; i++) begin
            if (r_tapCnt == TAP_W'(i)) r_kernel[i] <= w_data;
         end
      end
   end

   always_comb begin
      weights_output = '0;
      for (int i = 0; i < TAPS; i++) weights_output[2*i +: 2] = r_kernel[i];
   end

   assign w_ready           = (r_state == COLLECT);
   assign feature_WrEn      = (r_state != WRITE);
   assign feature_writeAddr = r_featCnt;
   assign busy              = (r_state != IDLE);
   assign load_done         = (r_state == DONE);

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Parameters
- KERNEL_SIZE, default 3: kernel edge; KERNEL_SIZE*KERNEL_SIZE taps per feature.
- NUM_FEATURES, default 2: number of feature kernels loaded per load sequence.

Interface
- REQ-001 clk  input  1  single clock; all state updates on rising edge.
- REQ-002 rst_loader  input  1  reset, asynchronous, active-low.
- REQ-003 start_n  input  1  active-low request to begin a full load sequence; sampled only in IDLE.
- REQ-004 w_valid  input  1  upstream weight valid.
- REQ-005 w_data  input  2 signed  one weight tap (-2..+1), row-major tap order.
- REQ-006 w_ready  output  1  loader accepts w_data this cycle.
- REQ-007 weights_output  output  2 signed x KERNEL_SIZE*KERNEL_SIZE  assembled kernel presented to the feature memory.
- REQ-008 feature_writeAddr  output  $clog2(NUM_FEATURES)+1  feature number being written.
- REQ-009 feature_WrEn  output  1  active-low write strobe to the feature memory.
- REQ-010 busy  output  1  high in any state other than IDLE.
- REQ-011 load_done  output  1  one-cycle high pulse at the end of a complete sequence.

Function
- REQ-012 FSM states SHALL be IDLE, COLLECT, WRITE, DONE; encoding free.
- REQ-013 IDLE: w_ready=0, feature_WrEn=1; start_n==0 -> COLLECT, feature counter=0, tap counter=0.
- REQ-014 start_n SHALL be ignored in COLLECT, WRITE, DONE; no restart or queuing.
- REQ-015 COLLECT: w_ready=1; transfer occurs only when w_valid && w_ready at a rising edge.
- REQ-016 On each transfer, w_data SHALL be stored in kernel register [tap counter], and the tap counter SHALL increment by 1.
- REQ-017 Transfer at tap counter == KERNEL_SIZE*KERNEL_SIZE-1 -> WRITE next cycle; w_valid low holds state and counters unchanged.
- REQ-018 WRITE lasts exactly one cycle: feature_WrEn=0, feature_writeAddr=feature counter, weights_output=complete kernel, w_ready=0.
- REQ-019 After WRITE: feature counter == NUM_FEATURES-1 -> DONE; otherwise feature counter+1, tap counter=0 -> COLLECT.
- REQ-020 DONE lasts one cycle with load_done=1, then -> IDLE; load_done=0 in all other states.
- REQ-021 weights_output SHALL reflect the kernel register at all times; consumers sample it only while feature_WrEn=0.
- REQ-022 feature_writeAddr SHALL equal the feature counter at all times; its value outside WRITE has no effect.
- REQ-023 feature_WrEn SHALL be low in at most one cycle per feature; no write is issued for a partial kernel.
- REQ-024 Latency: WRITE occurs the cycle after the last tap's transfer; minimum sequence length from start_n accepted to load_done = NUM_FEATURES*(KERNEL_SIZE*KERNEL_SIZE+1)+1 cycles.
- REQ-025 w_data values 2'b10 (-2) through 2'b01 (+1) are all legal and SHALL be stored unmodified.
- REQ-026 Kernel register SHALL NOT be cleared between features; every tap is overwritten before the next WRITE.

Reset
- REQ-027 rst_loader low SHALL immediately force: state IDLE, counters 0, kernel register all 0, w_ready=0, feature_WrEn=1, feature_writeAddr=0, busy=0, load_done=0.
- REQ-028 Reset asserted mid-sequence SHALL abort without issuing any further write; features already written are not revisited.
- REQ-029 After reset release, the loader SHALL wait in IDLE for a new start_n.

Verification
- REQ-030 Full load: start_n pulse, stream 18 taps with w_valid held high (feature0 all +1, feature1 all -1) -> WrEn low at cycle 10 with addr 0 and kernel all 2'b01, low at cycle 20 with addr 1 and kernel all 2'b11, load_done at cycle 21.
- REQ-031 Backpressure: w_valid toggled every other cycle -> taps stored in order 0..8 only on valid cycles; WrEn low once per feature; no extra writes.
- REQ-032 Value range: feature0 taps -2,-1,0,1,-2,-1,0,1,-2 -> weights_output at WRITE matches exactly, index 0 = 2'b10.
- REQ-033 Ignored start: start_n held low throughout the sequence -> exactly one sequence, returns to IDLE, then restarts only if start_n still low in IDLE.
- REQ-034 Reset mid-operation: assert rst_loader after 5 taps of feature1 -> all outputs reach reset values immediately, WrEn never low for feature1, busy=0 until next start_n.
- REQ-035 Idle input: w_valid high while in IDLE -> w_ready=0, kernel register unchanged, no write.
